// File: rtl/alu_req_scheduler_if.sv
// Requester/ALU signal bundle for alu_req_scheduler.
// master: requesters plus the shared ALU; slave: the scheduler.
interface alu_req_scheduler_if #(
  parameter int unsigned BITS = 5
);
  // Requester side
  logic            req0;
  logic            req1;
  logic [1:0]      op0;
  logic [1:0]      op1;
  logic [BITS-1:0] a0;
  logic [BITS-1:0] b0;
  logic [BITS-1:0] a1;
  logic [BITS-1:0] b1;
  logic            done0;
  logic            done1;

  // Shared ALU side
  logic [BITS-1:0] alu_a;
  logic [BITS-1:0] alu_b;
  logic [1:0]      alu_ctrl;
  logic [BITS-1:0] alu_result;
  logic [3:0]      alu_flags;

  // Status and completed-operation outputs
  logic [BITS-1:0] result;
  logic [3:0]      flags;
  logic            busy;
  logic            grant_id;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_result, alu_flags,
    input  done0, done1, alu_a, alu_b, alu_ctrl, result, flags, busy, grant_id
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_result, alu_flags,
    output done0, done1, alu_a, alu_b, alu_ctrl, result, flags, busy, grant_id
  );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational 4-op ALU between two
// requesters; IDLE -> EXEC -> DONE per operation with a one-cycle done pulse.
module alu_req_scheduler #(
  parameter int unsigned BITS = 5
) (
  input logic               clk,
  input logic               reset,
  alu_req_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [1:0]      op_q;
  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;
  logic [BITS-1:0] result_q;
  logic [3:0]      flags_q;
  logic            grant_q;
  logic            last_q;
  logic            mask_q;

  logic            elig0;
  logic            elig1;
  logic            win_any;
  logic            winner;

  // mask_q is high only in the IDLE cycle right after DONE; it blocks the
  // requester just served (grant_q) so a late-dropping req is not re-served.
  always_comb begin
    elig0   = bus.req0 & ~(mask_q & ~grant_q);
    elig1   = bus.req1 & ~(mask_q &  grant_q);
    win_any = elig0 | elig1;
    winner  = (elig0 & elig1) ? ~last_q : elig1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_any) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      mask_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      mask_q <= (state == DONE);
      if (state == IDLE && win_any) begin
        op_q    <= winner ? bus.op1 : bus.op0;
        a_q     <= winner ? bus.a1  : bus.a0;
        b_q     <= winner ? bus.b1  : bus.b0;
        grant_q <= winner;
        last_q  <= winner;
      end
      if (state == EXEC) begin
        result_q <= bus.alu_result;
        flags_q  <= bus.alu_flags;
      end
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_ctrl = op_q;
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_q;
  assign bus.done0    = (state == DONE) & ~grant_q;
  assign bus.done1    = (state == DONE) &  grant_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a behavioural shared ALU.
module tb_alu_req_scheduler;
  localparam int unsigned W = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_req_scheduler_if #(.BITS(W)) bus ();

  alu_req_scheduler #(.BITS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add/sub/and/or with {N,Z,C,V}; C on sub means no borrow.
  logic [W:0]   alu_s;
  logic [W-1:0] alu_r;
  logic         alu_c;
  logic         alu_v;
  always_comb begin
    alu_s = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.alu_ctrl)
      2'b00: begin
        alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_r = alu_s[W-1:0];
        alu_c = alu_s[W];
        alu_v = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (alu_r[W-1] != bus.alu_a[W-1]);
      end
      2'b01: begin
        alu_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 1'b1;
        alu_r = alu_s[W-1:0];
        alu_c = alu_s[W];
        alu_v = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (alu_r[W-1] != bus.alu_a[W-1]);
      end
      2'b10: alu_r = bus.alu_a & bus.alu_b;
      default: alu_r = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_result = alu_r;
    bus.alu_flags  = {alu_r[W-1], (alu_r == '0), alu_c, alu_v};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.op1 = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    #2 reset = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_done0", bus.done0, 0);
    chk("rst_done1", bus.done1, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single add 3+4
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 5'd3; bus.b0 = 5'd4;
    tick();
    chk("add_exec_busy", bus.busy, 1);
    chk("add_exec_alu_a", bus.alu_a, 3);
    chk("add_exec_alu_b", bus.alu_b, 4);
    chk("add_exec_done0", bus.done0, 0);
    tick();
    chk("add_done0", bus.done0, 1);
    chk("add_done1", bus.done1, 0);
    chk("add_result", bus.result, 7);
    chk("add_flags", bus.flags, 0);
    chk("add_done_busy", bus.busy, 1);
    bus.req0 = 1'b0;
    tick();
    chk("add_idle_busy", bus.busy, 0);
    chk("add_idle_done0", bus.done0, 0);
    chk("add_hold_result", bus.result, 7);
    tick();

    // Reset clears completed result; then first contention goes to requester 0
    reset = 1'b1;
    #1;
    chk("rst2_result", bus.result, 0);
    tick();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.op0 = 2'b10; bus.a0 = 5'b10110; bus.b0 = 5'b01110;
    bus.req1 = 1'b1; bus.op1 = 2'b11; bus.a1 = 5'd1;     bus.b1 = 5'd2;
    tick();
    chk("cont_exec_grant", bus.grant_id, 0);
    tick();
    chk("cont_done0", bus.done0, 1);
    chk("cont_done0_result", bus.result, 5'b00110);
    bus.req0 = 1'b0;
    tick();
    chk("cont_idle_done1", bus.done1, 0);
    tick();
    chk("cont_exec1_grant", bus.grant_id, 1);
    tick();
    chk("cont_done1", bus.done1, 1);
    chk("cont_done1_done0", bus.done0, 0);
    chk("cont_done1_result", bus.result, 3);
    bus.req1 = 1'b0;
    tick();

    // Fairness: both held for 12 cycles
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 5'd1; bus.b0 = 5'd1;
    bus.req1 = 1'b1; bus.op1 = 2'b00; bus.a1 = 5'd2; bus.b1 = 5'd2;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("fair_done0", bus.done0, (k == 2 || k == 8));
      chk("fair_done1", bus.done1, (k == 5 || k == 11));
      chk("fair_grant", bus.grant_id, ((k - 1) / 3) % 2);
      if (k == 2 || k == 8) chk("fair_result0", bus.result, 2);
      if (k == 5 || k == 11) chk("fair_result1", bus.result, 4);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // Operand isolation: sub 9-2 with a1 changed during EXEC
    bus.req1 = 1'b1; bus.op1 = 2'b01; bus.a1 = 5'd9; bus.b1 = 5'd2;
    tick();
    chk("iso_exec_alu_a", bus.alu_a, 9);
    chk("iso_exec_ctrl", bus.alu_ctrl, 1);
    bus.a1 = 5'd0; bus.op1 = 2'b00; bus.b1 = 5'd5;
    #3;
    chk("iso_exec_alu_a_late", bus.alu_a, 9);
    chk("iso_exec_alu_b_late", bus.alu_b, 2);
    tick();
    chk("iso_done1", bus.done1, 1);
    chk("iso_result", bus.result, 7);
    chk("iso_flags", bus.flags, 4'b0010);
    bus.req1 = 1'b0;
    tick();
    chk("iso_idle_done1", bus.done1, 0);
    tick();
    chk("iso_idle2_done1", bus.done1, 0);
    chk("iso_hold_alu_a", bus.alu_a, 9);

    // Masking: req0 alone, served every 4 cycles
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 5'd1; bus.b0 = 5'd1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("mask_done0", bus.done0, (k % 4 == 2));
      chk("mask_done1", bus.done1, 0);
    end
    tick();
    chk("mrst_exec_busy", bus.busy, 1);
    chk("mrst_pre_result", bus.result, 2);

    // Reset mid-EXEC
    reset = 1'b1;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_result", bus.result, 0);
    chk("mrst_flags", bus.flags, 0);
    chk("mrst_done0", bus.done0, 0);
    chk("mrst_alu_a", bus.alu_a, 0);
    tick();
    chk("mrst_hold_done0", bus.done0, 0);
    reset = 1'b0;
    tick();
    chk("mrst_exec_again", bus.busy, 1);
    chk("mrst_exec_alu_a", bus.alu_a, 1);
    tick();
    chk("mrst_done0_again", bus.done0, 1);
    chk("mrst_result_again", bus.result, 2);
    bus.req0 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
